store_line_merge: RTL

// Store-side counterpart of the load data aligner: takes right-aligned store data (B/H/W/D) plus byte address,

---
 rtl/store_line_merge_if.sv | 28 ++
 rtl/store_line_merge.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/store_line_merge_if.sv
// Store-commit request and cache line-write bundle for store_line_merge.
// The slave modport is the merge buffer's view; master is the driver/observer side.
interface store_line_merge_if #(
  parameter int ADDR_W = 64
);
  logic              st_valid_i;
  logic              st_ready_o;
  logic [ADDR_W-1:0] st_addr_i;
  logic [1:0]        st_size_i;
  logic [63:0]       st_data_i;
  logic              flush_i;
  logic              idle_o;
  logic              line_valid_o;
  logic              line_ready_i;
  logic [ADDR_W-1:0] line_addr_o;
  logic [127:0]      line_data_o;
  logic [15:0]       line_be_o;

  modport slave (
    input  st_valid_i, st_addr_i, st_size_i, st_data_i, flush_i, line_ready_i,
    output st_ready_o, idle_o, line_valid_o, line_addr_o, line_data_o, line_be_o
  );

  modport master (
    output st_valid_i, st_addr_i, st_size_i, st_data_i, flush_i, line_ready_i,
    input  st_ready_o, idle_o, line_valid_o, line_addr_o, line_data_o, line_be_o
  );
endinterface

// File: rtl/store_line_merge.sv
// Store line merge buffer: aligns right-justified B/H/W/D store data into its
// 128-bit line position, builds the byte mask, and coalesces consecutive stores
// to the same line before draining the line to the D-cache write port.
module store_line_merge #(
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  store_line_merge_if.slave  bus
);
  localparam int TAG_W = ADDR_W - 4;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_MERGE,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic [TAG_W-1:0] r_tag;
  logic [127:0]     r_data;
  logic [15:0]      r_be;
  logic [TMR_W-1:0] r_timer;
  logic             r_line_valid;

  logic [3:0]       w_off;
  logic [63:0]      w_sized;
  logic [15:0]      w_mask_base;
  logic [15:0]      w_mask;
  logic [127:0]     w_aligned;
  logic [127:0]     w_merged;
  logic [15:0]      w_be_next;
  logic             w_tag_match;
  logic             w_ready;
  logic             w_accept;

  // Size-dependent offset rounding, data truncation and base byte mask.
  always_comb begin
    w_off       = bus.st_addr_i[3:0];
    w_sized     = bus.st_data_i;
    w_mask_base = 16'h00FF;
    case (bus.st_size_i)
      2'd0: begin
        w_off       = bus.st_addr_i[3:0];
        w_sized     = {56'd0, bus.st_data_i[7:0]};
        w_mask_base = 16'h0001;
      end
      2'd1: begin
        w_off       = {bus.st_addr_i[3:1], 1'b0};
        w_sized     = {48'd0, bus.st_data_i[15:0]};
        w_mask_base = 16'h0003;
      end
      2'd2: begin
        w_off       = {bus.st_addr_i[3:2], 2'b00};
        w_sized     = {32'd0, bus.st_data_i[31:0]};
        w_mask_base = 16'h000F;
      end
      default: begin
        w_off       = {bus.st_addr_i[3], 3'b000};
        w_sized     = bus.st_data_i;
        w_mask_base = 16'h00FF;
      end
    endcase
  end

  assign w_aligned = {64'd0, w_sized} << {w_off, 3'b000};
  assign w_mask    = w_mask_base << w_off;
  assign w_be_next = r_be | w_mask;

  // Byte-wise overlay of the incoming store onto the buffered line; newest store wins.
  always_comb begin
    w_merged = r_data;
    for (int i = 0; i < 16; i++) begin
      if (w_mask[i]) begin
        w_merged[i*8 +: 8] = w_aligned[i*8 +: 8];
      end
    end
  end

  assign w_tag_match = (bus.st_addr_i[ADDR_W-1:4] == r_tag);

  // In MERGE only same-line stores get in, and a flush takes priority over them.
  always_comb begin
    w_ready = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_EMPTY: w_ready = 1'b1;
        S_MERGE: w_ready = bus.st_valid_i && w_tag_match && !bus.flush_i;
        default: w_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = bus.st_valid_i && w_ready;

  // Merge buffer state machine: capture, coalesce, then hold the line until the cache takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_tag        <= '0;
      r_data       <= '0;
      r_be         <= '0;
      r_timer      <= '0;
      r_line_valid <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_tag   <= bus.st_addr_i[ADDR_W-1:4];
            r_data  <= w_aligned;
            r_be    <= w_mask;
            r_timer <= '0;
            r_state <= S_MERGE;
          end
        end
        S_MERGE: begin
          if (w_accept) begin
            r_data  <= w_merged;
            r_be    <= w_be_next;
            r_timer <= '0;
            if (w_be_next == 16'hFFFF) begin
              r_state      <= S_DRAIN;
              r_line_valid <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
            if (bus.flush_i || bus.st_valid_i || (r_timer == TMR_LAST)) begin
              r_state      <= S_DRAIN;
              r_line_valid <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (bus.line_ready_i) begin
            r_state      <= S_EMPTY;
            r_line_valid <= 1'b0;
            r_tag        <= '0;
            r_data       <= '0;
            r_be         <= '0;
            r_timer      <= '0;
          end
        end
        default: begin
          r_state      <= S_EMPTY;
          r_line_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.st_ready_o   = w_ready;
  assign bus.idle_o       = (r_state == S_EMPTY);
  assign bus.line_valid_o = r_line_valid;
  assign bus.line_addr_o  = {r_tag, 4'h0};
  assign bus.line_data_o  = r_data;
  assign bus.line_be_o    = r_be;

endmodule
